voice_allocator: RTL and testbench

VOICE_ALLOCATOR -- requirements
Module: voice_allocator

---
 rtl/voice_allocator_pkg.sv | 33 +++
 rtl/voice_allocator_slot.sv | 40 ++++
 rtl/voice_allocator.sv | 166 ++++++++++++++++
 tb/tb_voice_allocator.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/voice_allocator_pkg.sv
// Shared constants and types for the voice allocator and its oscillator wrapper.
package voice_allocator_pkg;

  // Key number width (MIDI-style 0..127, 0 = no note).
  localparam int KEY_W          = 7;
  // Oscillator wavetable depth, used by the wrapper that owns the oscillators.
  localparam int OSC_DEPTH      = 256;
  // Default polyphony.
  localparam int NUM_VOICES_DEF = 4;

  typedef logic [KEY_W-1:0] key_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  // Per-voice action decided at the end of a scan.
  typedef enum logic [1:0] {
    OP_NONE    = 2'd0,
    OP_RETRIG  = 2'd1,
    OP_ASSIGN  = 2'd2,
    OP_RELEASE = 2'd3
  } op_e;

  // Captured copy of an accepted event.
  typedef struct packed {
    logic on;
    key_t key;
  } event_t;

endpackage

// File: rtl/voice_allocator_slot.sv
// One voice: gate, key and saturating age register with allocator controls.
module voice_allocator_slot
  import voice_allocator_pkg::*;
#(
  parameter int AGE_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             do_assign,
  input  logic             do_retrig,
  input  logic             do_release,
  input  logic             do_age,
  input  key_t             new_key,
  output logic             gate,
  output key_t             key,
  output logic [AGE_W-1:0] age
);

  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  // Voice state; assign wins over retrigger, release and aging. Ungated ages freeze.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate <= 1'b0;
      key  <= '0;
      age  <= '0;
    end else if (do_assign) begin
      gate <= 1'b1;
      key  <= new_key;
      age  <= '0;
    end else if (do_retrig) begin
      age  <= '0;
    end else if (do_release) begin
      gate <= 1'b0;
    end else if (do_age && gate && (age != AGE_MAX)) begin
      age  <= age + AGE_W'(1);
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: accepts note events, scans voices one per cycle,
// then commits a retrigger / allocate / steal / release decision.
module voice_allocator
  import voice_allocator_pkg::*;
#(
  parameter int NUM_VOICES = NUM_VOICES_DEF,
  parameter int AGE_W      = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ev_valid,
  output logic                        ev_ready,
  input  logic                        ev_on,
  input  logic [KEY_W-1:0]            ev_key,
  output logic [NUM_VOICES*KEY_W-1:0] voice_key,
  output logic [NUM_VOICES-1:0]       voice_gate,
  output logic                        steal
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  state_e state, state_nxt;
  event_t ev_q;

  logic [IDX_W-1:0] idx;
  logic             match_vld, free_vld;
  logic [IDX_W-1:0] match_idx, free_idx, old_idx;
  logic [AGE_W-1:0] old_age;

  logic [NUM_VOICES-1:0]            slot_gate;
  logic [NUM_VOICES-1:0][KEY_W-1:0] slot_key;
  logic [NUM_VOICES-1:0][AGE_W-1:0] slot_age;

  logic             cur_gate;
  key_t             cur_key;
  logic [AGE_W-1:0] cur_age;

  op_e              op;
  logic [IDX_W-1:0] tgt;
  logic             age_others;
  logic             do_steal;

  assign cur_gate   = slot_gate[idx];
  assign cur_key    = slot_key[idx];
  assign cur_age    = slot_age[idx];
  assign voice_key  = slot_key;
  assign voice_gate = slot_gate;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state and handshake; one event in flight, ready only while idle.
  always_comb begin
    state_nxt = state;
    ev_ready  = 1'b0;
    case (state)
      ST_IDLE: begin
        ev_ready = 1'b1;
        if (ev_valid) state_nxt = ST_SCAN;
      end
      ST_SCAN:   if (idx == LAST_IDX) state_nxt = ST_COMMIT;
      ST_COMMIT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Capture the event, then walk the voices tracking first match, first free
  // voice and oldest gated voice (strict > keeps the lowest index on ties).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_q      <= '0;
      idx       <= '0;
      match_vld <= 1'b0;
      match_idx <= '0;
      free_vld  <= 1'b0;
      free_idx  <= '0;
      old_idx   <= '0;
      old_age   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ev_valid) begin
            ev_q      <= '{on: ev_on, key: ev_key};
            idx       <= '0;
            match_vld <= 1'b0;
            free_vld  <= 1'b0;
            old_idx   <= '0;
            old_age   <= '0;
          end
        end
        ST_SCAN: begin
          idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
          if (cur_gate && (cur_key == ev_q.key) && !match_vld) begin
            match_vld <= 1'b1;
            match_idx <= idx;
          end
          if (!cur_gate && !free_vld) begin
            free_vld <= 1'b1;
            free_idx <= idx;
          end
          if (cur_gate && (cur_age > old_age)) begin
            old_idx <= idx;
            old_age <= cur_age;
          end
        end
        default: ;
      endcase
    end
  end

  // Commit decision; key 0 events and unmatched note-offs do nothing.
  always_comb begin
    op         = OP_NONE;
    tgt        = '0;
    age_others = 1'b0;
    do_steal   = 1'b0;
    if (state == ST_COMMIT && ev_q.key != '0) begin
      if (ev_q.on) begin
        age_others = 1'b1;
        if (match_vld) begin
          op  = OP_RETRIG;
          tgt = match_idx;
        end else if (free_vld) begin
          op  = OP_ASSIGN;
          tgt = free_idx;
        end else begin
          op       = OP_ASSIGN;
          tgt      = old_idx;
          do_steal = 1'b1;
        end
      end else if (match_vld) begin
        op  = OP_RELEASE;
        tgt = match_idx;
      end
    end
  end

  // Steal pulse lines up with the commit edge and lasts one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) steal <= 1'b0;
    else        steal <= do_steal;
  end

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_slot
    logic sel;
    assign sel = (tgt == IDX_W'(i));

    voice_allocator_slot #(.AGE_W(AGE_W)) u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .do_assign  ((op == OP_ASSIGN)  && sel),
      .do_retrig  ((op == OP_RETRIG)  && sel),
      .do_release ((op == OP_RELEASE) && sel),
      .do_age     (age_others && !sel),
      .new_key    (ev_q.key),
      .gate       (slot_gate[i]),
      .key        (slot_key[i]),
      .age        (slot_age[i])
    );
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: directed table, handshake and reset
// corner cases, then random events against a behavioural voice model.
module tb_voice_allocator;
  import voice_allocator_pkg::*;

  localparam int NV   = 4;
  localparam int AW   = 3;
  localparam int AMAX = (1 << AW) - 1;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   ev_valid = 1'b0;
  logic                   ev_on = 1'b0;
  logic [KEY_W-1:0]       ev_key = '0;
  logic                   ev_ready;
  logic [NV*KEY_W-1:0]    voice_key;
  logic [NV-1:0]          voice_gate;
  logic                   steal;

  always #5 clk = ~clk;

  voice_allocator #(.NUM_VOICES(NV), .AGE_W(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_on      (ev_on),
    .ev_key     (ev_key),
    .voice_key  (voice_key),
    .voice_gate (voice_gate),
    .steal      (steal)
  );

  int errors = 0;
  int checks = 0;

  // Reference voice pool.
  int mk[NV];
  int mg[NV];
  int ma[NV];

  typedef struct {
    bit                  on;
    int                  key;
    logic [NV*KEY_W-1:0] ek;
    logic [NV-1:0]       eg;
    bit                  es;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NV*KEY_W-1:0] kv(input int k0, input int k1, input int k2, input int k3);
    logic [NV*KEY_W-1:0] r;
    r = {KEY_W'(k3), KEY_W'(k2), KEY_W'(k1), KEY_W'(k0)};
    return r;
  endfunction

  function automatic logic [NV*KEY_W-1:0] model_keys();
    logic [NV*KEY_W-1:0] r;
    r = '0;
    for (int j = 0; j < NV; j++) r[j*KEY_W +: KEY_W] = KEY_W'(mk[j]);
    return r;
  endfunction

  function automatic logic [NV-1:0] model_gates();
    logic [NV-1:0] r;
    r = '0;
    for (int j = 0; j < NV; j++) r[j] = (mg[j] != 0);
    return r;
  endfunction

  task automatic model_reset();
    for (int j = 0; j < NV; j++) begin
      mk[j] = 0; mg[j] = 0; ma[j] = 0;
    end
  endtask

  // Allocation rules: retrigger a sounding key, else first silent voice, else
  // the oldest sounding voice (first one on ties); note-off silences first holder.
  task automatic model_apply(input bit on, input int key, output bit stl);
    int hit;
    int tgt;
    stl = 0;
    if (key == 0) return;
    hit = -1;
    for (int j = NV-1; j >= 0; j--) if (mg[j] != 0 && mk[j] == key) hit = j;
    if (on) begin
      tgt = hit;
      if (tgt < 0) for (int j = NV-1; j >= 0; j--) if (mg[j] == 0) tgt = j;
      if (tgt < 0) begin
        int best;
        best = -1;
        for (int j = 0; j < NV; j++) if (ma[j] > best) begin best = ma[j]; tgt = j; end
        stl = 1;
      end
      for (int j = 0; j < NV; j++)
        if (j != tgt && mg[j] != 0) ma[j] = (ma[j] + 1 > AMAX) ? AMAX : ma[j] + 1;
      mk[tgt] = key;
      mg[tgt] = 1;
      ma[tgt] = 0;
    end else if (hit >= 0) begin
      mg[hit] = 0;
    end
  endtask

  // Hand one event over, scramble the inputs afterwards, and check that outputs
  // hold through the scan and change exactly NV+1 cycles after the transfer.
  task automatic send(input bit on, input int key);
    int w;
    bit stl;
    logic [NV*KEY_W-1:0] old_k;
    logic [NV-1:0]       old_g;
    w = 0;
    while (!ev_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    chk("ready_before_send", 64'(ev_ready), 64'(1));
    old_k = model_keys();
    old_g = model_gates();
    ev_valid = 1'b1;
    ev_on    = on;
    ev_key   = KEY_W'(key);
    @(posedge clk); #1;
    ev_valid = 1'b0;
    ev_on    = 1'($urandom);
    ev_key   = KEY_W'($urandom);
    model_apply(on, key, stl);
    repeat (NV) @(posedge clk);
    #1;
    chk("key_held_in_scan",  64'(voice_key),  64'(old_k));
    chk("gate_held_in_scan", 64'(voice_gate), 64'(old_g));
    chk("steal_low_in_scan", 64'(steal),      64'(0));
    @(posedge clk); #1;
    chk("key_after_commit",   64'(voice_key),  64'(model_keys()));
    chk("gate_after_commit",  64'(voice_gate), 64'(model_gates()));
    chk("steal_after_commit", 64'(steal),      64'(stl));
    @(posedge clk); #1;
    chk("steal_one_cycle", 64'(steal), 64'(0));
  endtask

  initial begin
    model_reset();

    tbl[0]  = '{1, 40, kv(40, 0, 0, 0),    4'b0001, 0};
    tbl[1]  = '{1, 44, kv(40, 44, 0, 0),   4'b0011, 0};
    tbl[2]  = '{1, 47, kv(40, 44, 47, 0),  4'b0111, 0};
    tbl[3]  = '{1, 52, kv(40, 44, 47, 52), 4'b1111, 0};
    tbl[4]  = '{1, 56, kv(56, 44, 47, 52), 4'b1111, 1};
    tbl[5]  = '{0, 44, kv(56, 44, 47, 52), 4'b1101, 0};
    tbl[6]  = '{1, 60, kv(56, 60, 47, 52), 4'b1111, 0};
    tbl[7]  = '{1, 47, kv(56, 60, 47, 52), 4'b1111, 0};
    tbl[8]  = '{0, 70, kv(56, 60, 47, 52), 4'b1111, 0};
    tbl[9]  = '{1, 0,  kv(56, 60, 47, 52), 4'b1111, 0};
    // Voice 2 was just retriggered, so voice 3 is now the oldest.
    tbl[10] = '{1, 64, kv(56, 60, 47, 64), 4'b1111, 1};
    tbl[11] = '{0, 0,  kv(56, 60, 47, 64), 4'b1111, 0};

    // Reset state.
    #2;
    chk("rst_gate",  64'(voice_gate), 64'(0));
    chk("rst_key",   64'(voice_key),  64'(0));
    chk("rst_steal", 64'(steal),      64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", 64'(ev_ready), 64'(1));

    // Directed table.
    for (int i = 0; i < 12; i++) begin
      logic st_commit;
      send(tbl[i].on, tbl[i].key);
      // steal was sampled inside send; recheck table keys/gates against constants.
      st_commit = tbl[i].es;
      chk($sformatf("tbl%0d_key", i),  64'(voice_key),  64'(tbl[i].ek));
      chk($sformatf("tbl%0d_gate", i), 64'(voice_gate), 64'(tbl[i].eg));
      chk($sformatf("tbl%0d_model_steal_agrees", i), 64'(st_commit), 64'(tbl[i].es));
    end

    // Continuous ev_valid with key 0: ready once every NV+2 cycles, outputs frozen.
    ev_valid = 1'b1;
    ev_on    = 1'b1;
    ev_key   = '0;
    for (int c = 0; c < 3 * (NV + 2); c++) begin
      chk($sformatf("ready_pattern_c%0d", c), 64'(ev_ready), 64'((c % (NV + 2)) == 0));
      @(posedge clk); #1;
    end
    ev_valid = 1'b0;
    chk("key0_stream_key",  64'(voice_key),  64'(model_keys()));
    chk("key0_stream_gate", 64'(voice_gate), 64'(model_gates()));

    // Reset in the middle of a scan drops the event.
    @(posedge clk); #1;
    chk("ready_before_rst_scan", 64'(ev_ready), 64'(1));
    ev_valid = 1'b1;
    ev_on    = 1'b1;
    ev_key   = KEY_W'(90);
    @(posedge clk); #1;
    ev_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midscan_rst_gate",  64'(voice_gate), 64'(0));
    chk("midscan_rst_key",   64'(voice_key),  64'(0));
    chk("midscan_rst_steal", 64'(steal),      64'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_midscan_rst", 64'(ev_ready), 64'(1));
    repeat (NV + 3) @(posedge clk);
    #1;
    chk("event_lost_gate", 64'(voice_gate), 64'(0));
    chk("event_lost_key",  64'(voice_key),  64'(0));

    // Random events over a small key range to force matches, steals and age saturation.
    for (int n = 0; n < 80; n++) begin
      bit on;
      int key;
      on  = ($urandom_range(0, 99) < 65);
      key = ($urandom_range(0, 9) == 0) ? 0 : 30 + $urandom_range(1, 10);
      send(on, key);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
